// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: shared types and constants for the stopwatch and countdown BCD counters
package bcd_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} cdt_state_t;
  typedef logic [3:0] bcd_digit_t;
  localparam int BCD_MAX = 9;
  localparam int SEC_TENS_MAX_DEF = 5;
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one registered BCD digit that decrements, wrapping to wrap_val and borrowing at zero
module bcd_digit_down #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec_in,
  input  logic [W-1:0] wrap_val,
  output logic [W-1:0] digit,
  output logic         borrow_out
);
  logic [W-1:0] digit_q, digit_d;
  always_comb
    digit_d = clr ? '0 : ld ? ld_val : !dec_in ? digit_q : (digit_q == '0) ? wrap_val : digit_q - 1'b1;
  always_ff @(posedge clk)
    if (rst) digit_q <= '0;
    else digit_q <= digit_d;
  assign digit = digit_q;
  assign borrow_out = dec_in && (digit_q == '0);
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: SS.mmm BCD countdown with load/start/pause/clear control and expiry flags.
// Define BCD_CDT_AUTO_RELOAD_EN to reload the preset on expiry instead of stopping.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter int DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1ms,
  input  logic               load,
  input  logic [DIGIT_W-1:0] pre_sec_tens,
  input  logic [DIGIT_W-1:0] pre_sec_ones,
  input  logic [DIGIT_W-1:0] pre_ms_hund,
  input  logic [DIGIT_W-1:0] pre_ms_tens,
  input  logic [DIGIT_W-1:0] pre_ms_units,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] ms_hund,
  output logic [DIGIT_W-1:0] ms_tens,
  output logic [DIGIT_W-1:0] ms_units,
  output logic               running,
  output logic               expired,
  output logic               done_pulse,
  output logic               load_err
);
  cdt_state_t state_q, state_d;
  logic done_q, done_d, err_q, err_d;
  logic clr_cnt, ld_cnt, dec;
  logic [DIGIT_W-1:0] pre [5];
  logic [DIGIT_W-1:0] cnt [5];
  logic [DIGIT_W-1:0] ld_src [5];
  logic [5*DIGIT_W-1:0] cnt_flat;
  logic [5:0] chain;
  logic chain_unused;
  logic valid, count_zero, count_one;
  assign pre = '{pre_ms_units, pre_ms_tens, pre_ms_hund, pre_sec_ones, pre_sec_tens};
  assign cnt_flat = {cnt[4], cnt[3], cnt[2], cnt[1], cnt[0]};
  assign count_zero = cnt_flat == '0;
  assign count_one = cnt_flat == (5*DIGIT_W)'(1);
  assign valid = pre_sec_tens <= DIGIT_W'(SEC_TENS_MAX) && pre_sec_ones <= DIGIT_W'(BCD_MAX) &&
                 pre_ms_hund <= DIGIT_W'(BCD_MAX) && pre_ms_tens <= DIGIT_W'(BCD_MAX) &&
                 pre_ms_units <= DIGIT_W'(BCD_MAX);
`ifdef BCD_CDT_AUTO_RELOAD_EN
  logic [DIGIT_W-1:0] preset_q [5];
  logic [DIGIT_W-1:0] preset_d [5];
  logic preset_zero;
  assign preset_zero = {preset_q[4], preset_q[3], preset_q[2], preset_q[1], preset_q[0]} == '0;
  always_ff @(posedge clk)
    if (rst) preset_q <= '{default: '0};
    else preset_q <= preset_d;
`endif
  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    err_d = 1'b0;
    clr_cnt = 1'b0;
    ld_cnt = 1'b0;
    dec = 1'b0;
    ld_src = pre;
`ifdef BCD_CDT_AUTO_RELOAD_EN
    preset_d = preset_q;
`endif
    if (clear) begin
      state_d = IDLE;
      clr_cnt = 1'b1;
    end else if (load && state_q != RUN) begin
      err_d = !valid;
      ld_cnt = valid;
      state_d = valid ? IDLE : state_q;
`ifdef BCD_CDT_AUTO_RELOAD_EN
      if (valid) preset_d = pre;
`endif
    end else if (pause && state_q == RUN) begin
      state_d = PAUSED;
    end else if (start && (state_q == IDLE || state_q == PAUSED)) begin
      state_d = count_zero ? EXPIRED : RUN;
      done_d = count_zero;
    end else if (tick_1ms && state_q == RUN) begin
      dec = 1'b1;
      if (count_one) begin
        done_d = 1'b1;
`ifdef BCD_CDT_AUTO_RELOAD_EN
        // reload replaces the final decrement so the period is exactly the preset
        if (!preset_zero) begin
          dec = 1'b0;
          ld_cnt = 1'b1;
          ld_src = preset_q;
        end else state_d = EXPIRED;
`else
        state_d = EXPIRED;
`endif
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign chain[0] = dec;
  assign chain_unused = chain[5];
  for (genvar i = 0; i < 5; i++) begin : g_dig
    bcd_digit_down #(.W(DIGIT_W)) u_dig (
      .clk(clk),
      .rst(rst),
      .clr(clr_cnt),
      .ld(ld_cnt),
      .ld_val(ld_src[i]),
      .dec_in(chain[i]),
      .wrap_val(i == 4 ? DIGIT_W'(SEC_TENS_MAX) : DIGIT_W'(BCD_MAX)),
      .digit(cnt[i]),
      .borrow_out(chain[i+1])
    );
  end
  assign {sec_tens, sec_ones, ms_hund, ms_tens, ms_units} = cnt_flat;
  assign running = state_q == RUN;
  assign expired = state_q == EXPIRED;
  assign done_pulse = done_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: table-driven directed checks plus long-count and reload sequences
module tb_bcd_countdown_timer;
  logic clk = 1'b0;
  logic rst = 1'b0, tick_1ms = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [3:0] pre_sec_tens = '0, pre_sec_ones = '0, pre_ms_hund = '0, pre_ms_tens = '0, pre_ms_units = '0;
  logic [3:0] sec_tens, sec_ones, ms_hund, ms_tens, ms_units;
  logic running, expired, done_pulse, load_err;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  bcd_countdown_timer dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .load(load),
    .pre_sec_tens(pre_sec_tens), .pre_sec_ones(pre_sec_ones), .pre_ms_hund(pre_ms_hund),
    .pre_ms_tens(pre_ms_tens), .pre_ms_units(pre_ms_units),
    .start(start), .pause(pause), .clear(clear),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .ms_hund(ms_hund), .ms_tens(ms_tens), .ms_units(ms_units),
    .running(running), .expired(expired), .done_pulse(done_pulse), .load_err(load_err)
  );
  typedef struct {
    string name;
    logic rs, cl, ld, pa, st, tk;
    logic [19:0] pr;
    logic [19:0] c;
    logic r, e, d, er;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input string n, input logic rs, cl, ld, pa, st, tk, input logic [19:0] pr,
                              input logic [19:0] c, input logic r, e, d, er);
    vec_t v;
    v.name = n; v.rs = rs; v.cl = cl; v.ld = ld; v.pa = pa; v.st = st; v.tk = tk; v.pr = pr;
    v.c = c; v.r = r; v.e = e; v.d = d; v.er = er;
    return v;
  endfunction
  task automatic drive(input logic rs, cl, ld, pa, st, tk, input logic [19:0] pr);
    @(negedge clk);
    rst = rs; clear = cl; load = ld; pause = pa; start = st; tick_1ms = tk;
    {pre_sec_tens, pre_sec_ones, pre_ms_hund, pre_ms_tens, pre_ms_units} = pr;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [23:0] exp_v);
    logic [23:0] act;
    act = {sec_tens, sec_ones, ms_hund, ms_tens, ms_units, running, expired, done_pulse, load_err};
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h (count,run/exp/done/err)", name, act, exp_v);
    end
  endtask
  task automatic chk_cond(input string name, input bit ok, input int got, input int want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask
  initial begin
    int dn;
    bit ex, run_ok;
    //                name       rs cl ld pa st tk pre        count      r  e  d  er
    tbl.push_back(mk("reset",     1, 0, 0, 0, 0, 0, 20'h00000, 20'h00000, 0, 0, 0, 0));
    tbl.push_back(mk("load5",     0, 0, 1, 0, 0, 0, 20'h00005, 20'h00005, 0, 0, 0, 0));
    tbl.push_back(mk("start5",    0, 0, 0, 0, 1, 0, 20'h00000, 20'h00005, 1, 0, 0, 0));
    tbl.push_back(mk("tick1",     0, 0, 0, 0, 0, 1, 20'h00000, 20'h00004, 1, 0, 0, 0));
    tbl.push_back(mk("tick2",     0, 0, 0, 0, 0, 1, 20'h00000, 20'h00003, 1, 0, 0, 0));
    tbl.push_back(mk("tick3",     0, 0, 0, 0, 0, 1, 20'h00000, 20'h00002, 1, 0, 0, 0));
    tbl.push_back(mk("tick4",     0, 0, 0, 0, 0, 1, 20'h00000, 20'h00001, 1, 0, 0, 0));
    tbl.push_back(mk("tick5_exp", 0, 0, 0, 0, 0, 1, 20'h00000, 20'h00000, 0, 1, 1, 0));
    tbl.push_back(mk("tick6_hold",0, 0, 0, 0, 0, 1, 20'h00000, 20'h00000, 0, 1, 0, 0));
    tbl.push_back(mk("exp_start", 0, 0, 0, 0, 1, 0, 20'h00000, 20'h00000, 0, 1, 0, 0));
    tbl.push_back(mk("bad_mst",   0, 0, 1, 0, 0, 0, 20'h000A0, 20'h00000, 0, 1, 0, 1));
    tbl.push_back(mk("bad_st6",   0, 0, 1, 0, 0, 0, 20'h60000, 20'h00000, 0, 1, 0, 1));
    tbl.push_back(mk("err_clr",   0, 0, 0, 0, 0, 0, 20'h00000, 20'h00000, 0, 1, 0, 0));
    tbl.push_back(mk("ld_over_st",0, 0, 1, 0, 1, 0, 20'h00100, 20'h00100, 0, 0, 0, 0));
    tbl.push_back(mk("start100",  0, 0, 0, 0, 1, 0, 20'h00000, 20'h00100, 1, 0, 0, 0));
    tbl.push_back(mk("pause_tick",0, 0, 0, 1, 0, 1, 20'h00000, 20'h00100, 0, 0, 0, 0));
    tbl.push_back(mk("pause_noop",0, 0, 0, 1, 0, 0, 20'h00000, 20'h00100, 0, 0, 0, 0));
    tbl.push_back(mk("ld_paused", 0, 0, 1, 0, 0, 0, 20'h00100, 20'h00100, 0, 0, 0, 0));
    tbl.push_back(mk("start_tick",0, 0, 0, 0, 1, 1, 20'h00000, 20'h00100, 1, 0, 0, 0));
    tbl.push_back(mk("tick_099",  0, 0, 0, 0, 0, 1, 20'h00000, 20'h00099, 1, 0, 0, 0));
    tbl.push_back(mk("ld_in_run", 0, 0, 1, 0, 0, 0, 20'h00005, 20'h00099, 1, 0, 0, 0));
    tbl.push_back(mk("badld_run", 0, 0, 1, 0, 0, 0, 20'h000A0, 20'h00099, 1, 0, 0, 0));
    tbl.push_back(mk("pa_over_st",0, 0, 0, 1, 1, 0, 20'h00000, 20'h00099, 0, 0, 0, 0));
    tbl.push_back(mk("resume",    0, 0, 0, 0, 1, 0, 20'h00000, 20'h00099, 1, 0, 0, 0));
    tbl.push_back(mk("tick_098",  0, 0, 0, 0, 0, 1, 20'h00000, 20'h00098, 1, 0, 0, 0));
    tbl.push_back(mk("clear_run", 0, 1, 0, 0, 0, 1, 20'h00000, 20'h00000, 0, 0, 0, 0));
    tbl.push_back(mk("ld12345",   0, 0, 1, 0, 0, 0, 20'h12345, 20'h12345, 0, 0, 0, 0));
    tbl.push_back(mk("st12345",   0, 0, 0, 0, 1, 0, 20'h00000, 20'h12345, 1, 0, 0, 0));
    tbl.push_back(mk("tick12344", 0, 0, 0, 0, 0, 1, 20'h00000, 20'h12344, 1, 0, 0, 0));
    tbl.push_back(mk("rst_mid",   1, 0, 0, 0, 0, 1, 20'h00000, 20'h00000, 0, 0, 0, 0));
    tbl.push_back(mk("start_zero",0, 0, 0, 0, 1, 0, 20'h00000, 20'h00000, 0, 1, 1, 0));
    tbl.push_back(mk("zero_hold", 0, 0, 0, 0, 0, 0, 20'h00000, 20'h00000, 0, 1, 0, 0));
    tbl.push_back(mk("clr_ovr_ld",0, 1, 1, 0, 0, 0, 20'h00300, 20'h00000, 0, 0, 0, 0));
    tbl.push_back(mk("ld10000",   0, 0, 1, 0, 0, 0, 20'h10000, 20'h10000, 0, 0, 0, 0));
    tbl.push_back(mk("st10000",   0, 0, 0, 0, 1, 0, 20'h00000, 20'h10000, 1, 0, 0, 0));
    tbl.push_back(mk("borrow_all",0, 0, 0, 0, 0, 1, 20'h00000, 20'h09999, 1, 0, 0, 0));
    tbl.push_back(mk("tick09998", 0, 0, 0, 0, 0, 1, 20'h00000, 20'h09998, 1, 0, 0, 0));
    foreach (tbl[k]) begin
      drive(tbl[k].rs, tbl[k].cl, tbl[k].ld, tbl[k].pa, tbl[k].st, tbl[k].tk, tbl[k].pr);
      chk(tbl[k].name, {tbl[k].c, tbl[k].r, tbl[k].e, tbl[k].d, tbl[k].er});
    end
    dn = 0;
    ex = 0;
    for (int k = 0; k < 9997; k++) begin
      drive(0, 0, 0, 0, 0, 1, 20'h0);
      dn += int'(done_pulse);
      ex |= expired;
    end
    chk_cond("long_no_early_done", dn == 0 && !ex, dn + int'(ex), 0);
    chk("long_at_001", {20'h00001, 4'b1000});
    drive(0, 0, 0, 0, 0, 1, 20'h0);
    chk("long_expire", {20'h00000, 4'b0110});
    drive(0, 0, 0, 0, 0, 1, 20'h0);
    chk("long_after", {20'h00000, 4'b0100});
`ifdef BCD_CDT_AUTO_RELOAD_EN
    drive(1, 0, 0, 0, 0, 0, 20'h0);
    drive(0, 0, 1, 0, 0, 0, 20'h00003);
    drive(0, 0, 0, 0, 1, 0, 20'h0);
    dn = 0;
    ex = 0;
    run_ok = 1;
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 0, 0, 0, 1, 20'h0);
      dn += int'(done_pulse);
      ex |= expired;
      run_ok &= running;
    end
    chk_cond("reload_done_count", dn == 3, dn, 3);
    chk_cond("reload_running", run_ok && !ex, int'(run_ok) * 2 + int'(ex), 2);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
